wm_cycle_scheduler: RTL and testbench

WM_CYCLE_SCHEDULER -- requirements
Module: wm_cycle_scheduler

---
 rtl/wm_cycle_scheduler.sv | 134 +++++++++++++
 tb/tb_wm_cycle_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wm_cycle_scheduler.sv
// Two-machine washer scheduler that time-shares one drum motor.
// Each machine snapshots its phase times on start; a round-robin pointer arbitrates.
module wm_cycle_scheduler #(
    parameter int TW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic [1:0]    start,
    input  logic [1:0]    abort,
    input  logic [TW-1:0] wash,
    input  logic [TW-1:0] rinse,
    input  logic [TW-1:0] spin,
    output logic [1:0]    pending,
    output logic [1:0]    grant,
    output logic [1:0]    phase,
    output logic [TW-1:0] remaining,
    output logic [1:0]    done
);
    localparam int NUM_M = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WASH  = 2'b01,
        RINSE = 2'b10,
        SPIN  = 2'b11
    } state_t;

    state_t        state, state_nx;
    logic          rr, rr_nx;
    logic [1:0]    grant_nx, pending_nx, done_nx, accept, elig;
    logic [TW-1:0] rem_nx;
    logic          own, win, advance;
    logic [TW-1:0] snap_w [NUM_M];
    logic [TW-1:0] snap_r [NUM_M];
    logic [TW-1:0] snap_s [NUM_M];

    // An abort in the same cycle beats a start for that machine.
    assign accept  = start & ~pending & ~grant & ~abort;
    assign own     = grant[1];
    assign advance = (remaining == '0) || (tick && remaining == TW'(1));
    assign phase   = state;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_M; i++) begin
            if (!rst_n) begin
                snap_w[i] <= '0;
                snap_r[i] <= '0;
                snap_s[i] <= '0;
            end else if (accept[i]) begin
                snap_w[i] <= wash;
                snap_r[i] <= rinse;
                snap_s[i] <= spin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= 1'b0;
            grant     <= '0;
            pending   <= '0;
            remaining <= '0;
            done      <= '0;
        end else begin
            state     <= state_nx;
            rr        <= rr_nx;
            grant     <= grant_nx;
            pending   <= pending_nx;
            remaining <= rem_nx;
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        rr_nx      = rr;
        grant_nx   = grant;
        rem_nx     = remaining;
        done_nx    = '0;
        pending_nx = (pending | accept) & ~abort;
        elig       = pending & ~abort;
        win        = elig[rr] ? rr : ~rr;

        case (state)
            IDLE: begin
                if (|elig) begin
                    state_nx = WASH;
                    grant_nx = win ? 2'b10 : 2'b01;
                    rem_nx   = snap_w[win];
                end
            end
            WASH: begin
                if (advance) begin
                    state_nx = RINSE;
                    rem_nx   = snap_r[own];
                end else if (tick) begin
                    rem_nx = remaining - TW'(1);
                end
            end
            RINSE: begin
                if (advance) begin
                    state_nx = SPIN;
                    rem_nx   = snap_s[own];
                end else if (tick) begin
                    rem_nx = remaining - TW'(1);
                end
            end
            SPIN: begin
                if (advance) begin
                    state_nx        = IDLE;
                    grant_nx        = '0;
                    rem_nx          = '0;
                    pending_nx[own] = 1'b0;
                    done_nx[own]    = 1'b1;
                    rr_nx           = ~own;
                end else if (tick) begin
                    rem_nx = remaining - TW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        // Aborting the running machine overrides any advance decided above.
        if (|(abort & grant)) begin
            state_nx = IDLE;
            grant_nx = '0;
            rem_nx   = '0;
            done_nx  = '0;
            rr_nx    = ~own;
        end
    end
endmodule

// File: tb/tb_wm_cycle_scheduler.sv
// Directed bench for wm_cycle_scheduler: reset, single job, contention,
// zero phases, abort, snapshot/ignore and mid-job reset.
module tb_wm_cycle_scheduler;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_n, tick;
    logic [1:0]    start, abort;
    logic [TW-1:0] wash, rinse, spin;
    logic [1:0]    pending, grant, phase, done;
    logic [TW-1:0] remaining;

    int checks   = 0;
    int failures = 0;

    wm_cycle_scheduler #(.TW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .abort(abort),
        .wash(wash), .rinse(rinse), .spin(spin), .pending(pending),
        .grant(grant), .phase(phase), .remaining(remaining), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_pend, input logic [1:0] e_grant,
                           input logic [1:0] e_phase, input logic [TW-1:0] e_rem,
                           input logic [1:0] e_done);
        chk({tag, ".pending"},   pending,   e_pend);
        chk({tag, ".grant"},     grant,     e_grant);
        chk({tag, ".phase"},     phase,     e_phase);
        chk({tag, ".remaining"}, remaining, e_rem);
        chk({tag, ".done"},      done,      e_done);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0]    exp_ph  [7];
        logic [TW-1:0] exp_rem [7];
        rst_n = 1'b0; tick = 1'b0; start = '0; abort = '0;
        wash = '0; rinse = '0; spin = '0;

        // Reset state
        do_reset();
        chk_all("reset", 2'b00, 2'b00, 2'b00, 5'd0, 2'b00);

        // Single job 3/2/1, tick every cycle
        wash = 5'd3; rinse = 5'd2; spin = 5'd1; tick = 1'b1;
        start = 2'b01;
        step();
        start = 2'b00;
        chk_all("single.accept", 2'b01, 2'b00, 2'b00, 5'd0, 2'b00);
        exp_ph  = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
        exp_rem = '{5'd3,  5'd2,  5'd1,  5'd2,  5'd1,  5'd1,  5'd0};
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("single.phase%0d", k), phase, exp_ph[k]);
            chk($sformatf("single.rem%0d", k), remaining, exp_rem[k]);
            chk($sformatf("single.grant%0d", k), grant, (k < 6) ? 2'b01 : 2'b00);
            chk($sformatf("single.done%0d", k), done, (k == 6) ? 2'b01 : 2'b00);
        end
        step();
        chk_all("single.after", 2'b00, 2'b00, 2'b00, 5'd0, 2'b00);

        // Contention from a fresh reset (rr=0)
        do_reset();
        wash = 5'd1; rinse = 5'd1; spin = 5'd1; tick = 1'b1;
        start = 2'b11;
        step();
        start = 2'b00;
        chk("cont.pending", pending, 2'b11);
        step();
        chk("cont.grant0", grant, 2'b01);
        step(); step(); step();
        chk("cont.done0", done, 2'b01);
        chk("cont.idle", grant, 2'b00);
        chk("cont.pend1", pending, 2'b10);
        step();
        chk("cont.grant1", grant, 2'b10);
        start = 2'b01;
        step();
        start = 2'b00;
        chk("cont.reaccept", pending, 2'b11);
        step(); step();
        chk("cont.done1", done, 2'b10);
        chk("cont.pend0", pending, 2'b01);
        step();
        chk("cont.grant0b", grant, 2'b01);
        step(); step(); step();
        chk("cont.done0b", done, 2'b01);

        // Zero-duration phases with tick held low
        wash = 5'd0; rinse = 5'd0; spin = 5'd0; tick = 1'b0;
        start = 2'b01;
        step();
        start = 2'b00;
        step();
        chk_all("zero.wash", 2'b01, 2'b01, 2'b01, 5'd0, 2'b00);
        step();
        chk_all("zero.rinse", 2'b01, 2'b01, 2'b10, 5'd0, 2'b00);
        step();
        chk_all("zero.spin", 2'b01, 2'b01, 2'b11, 5'd0, 2'b00);
        step();
        chk_all("zero.done", 2'b00, 2'b00, 2'b00, 5'd0, 2'b01);

        // Abort machine 0 in RINSE with remaining=4, machine 1 waiting
        wash = 5'd0; rinse = 5'd4; spin = 5'd1; tick = 1'b0;
        start = 2'b01;
        step();
        start = 2'b10;
        step();
        start = 2'b00;
        chk("abort.grant", grant, 2'b01);
        chk("abort.pend", pending, 2'b11);
        step();
        chk("abort.phase", phase, 2'b10);
        chk("abort.rem", remaining, 5'd4);
        abort = 2'b01;
        step();
        abort = 2'b00;
        chk_all("abort.idle", 2'b10, 2'b00, 2'b00, 5'd0, 2'b00);
        step();
        chk_all("abort.grant1", 2'b10, 2'b10, 2'b01, 5'd0, 2'b00);
        abort = 2'b10;
        step();
        abort = 2'b00;
        chk_all("abort.m1", 2'b00, 2'b00, 2'b00, 5'd0, 2'b00);

        // Snapshot: wash changes 7 -> 2 after acceptance; repeated start ignored
        wash = 5'd7; rinse = 5'd0; spin = 5'd0; tick = 1'b1;
        start = 2'b01;
        step();
        wash = 5'd2;
        step();
        chk("snap.rem7", remaining, 5'd7);
        chk("snap.wash", phase, 2'b01);
        for (int k = 0; k < 6; k++) step();
        chk("snap.last", phase, 2'b01);
        chk("snap.rem1", remaining, 5'd1);
        step();
        chk("snap.rinse", phase, 2'b10);
        step();
        chk("snap.spin", phase, 2'b11);
        step();
        start = 2'b00;
        chk_all("snap.done", 2'b00, 2'b00, 2'b00, 5'd0, 2'b01);
        step();
        chk_all("snap.noreq", 2'b00, 2'b00, 2'b00, 5'd0, 2'b00);

        // Reset during SPIN
        wash = 5'd1; rinse = 5'd1; spin = 5'd5; tick = 1'b1;
        start = 2'b01;
        step();
        start = 2'b00;
        step(); step(); step();
        chk("rst.spin", phase, 2'b11);
        chk("rst.rem", remaining, 5'd5);
        rst_n = 1'b0; start = 2'b01;
        step();
        chk_all("rst.clear", 2'b00, 2'b00, 2'b00, 5'd0, 2'b00);
        rst_n = 1'b1; start = 2'b00;
        step();
        chk_all("rst.nodone", 2'b00, 2'b00, 2'b00, 5'd0, 2'b00);
        start = 2'b01;
        step();
        start = 2'b00;
        chk("rst.pend", pending, 2'b01);
        step();
        chk("rst.grant", grant, 2'b01);
        chk("rst.wash", remaining, 5'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
